// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, instruction-format constants and FSM encoding for the fetch stage.
package fetch_pkg;
   localparam int ADDR_W_DEF   = 32;
   localparam int WORD_W_DEF   = 16;
   localparam int IMM_FLAG_BIT = 15;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register holding valid/instr/pc.
//   clk, rst (async active-low)   flush (clears to bubble, wins over load)
//   load (captures *_d)           valid/instr/pc (registered outputs)
module ifid_reg #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic               valid_d,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [ADDR_W-1:0]  pc_d,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (load) begin
         valid <= valid_d;
         instr <= instr_d;
         pc    <= pc_d;
      end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with next-PC logic, 1/2-word assembly FSM and IF/ID register.
//   clk, rst (async active-low)
//   pc -> imem_addr, pc_next/pc_we to the PC register
//   imem_data: combinational memory word; stall/redirect/redirect_pc from later stages
//   ifid_valid/ifid_instr/ifid_pc: registered IF/ID outputs
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   pc_next,
   output logic                pc_we,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [WORD_W-1:0]   imem_data,
   input  logic                stall,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                ifid_valid,
   output logic [2*WORD_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]   ifid_pc
);
   fetch_state_t        state, state_next;
   logic [WORD_W-1:0]   hold_word;
   logic [ADDR_W-1:0]   hold_pc;
   logic                two_word;
   logic                valid_d;
   logic [2*WORD_W-1:0] instr_d;
   logic [ADDR_W-1:0]   pc_d;

   assign imem_addr = pc;
   assign pc_we     = redirect | ~stall;
   assign pc_next   = redirect ? redirect_pc : pc + ADDR_W'(1);
   // Only meaningful in FIRST; the second word's flag is ignored.
   assign two_word  = imem_data[IMM_FLAG_BIT];

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= FIRST;
      else      state <= state_next;

   always_comb
      state_next = redirect                      ? FIRST  :
                   stall                         ? state  :
                   (state == FIRST && two_word)  ? SECOND : FIRST;

   always_comb begin
      valid_d = (state == SECOND) | ~two_word;
      instr_d = (state == SECOND) ? {hold_word, imem_data} :
                two_word          ? (2*WORD_W)'(NOP_INSTR) : {imem_data, {WORD_W{1'b0}}};
      pc_d    = (state == SECOND) ? hold_pc : two_word ? '0 : pc;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         hold_word <= '0;
         hold_pc   <= '0;
      end else if (redirect) begin
         hold_word <= '0;
         hold_pc   <= '0;
      end else if (!stall && state == FIRST && two_word) begin
         hold_word <= imem_data;
         hold_pc   <= pc;
      end

   // Redirect flushes even when stalled; a plain stall freezes the register.
   ifid_reg #(.ADDR_W(ADDR_W), .INSTR_W(2*WORD_W)) u_ifid (
      .clk     (clk),
      .rst     (rst),
      .load    (~stall),
      .flush   (redirect),
      .valid_d (valid_d),
      .instr_d (instr_d),
      .pc_d    (pc_d),
      .valid   (ifid_valid),
      .instr   (ifid_instr),
      .pc      (ifid_pc)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand sequences and random run against a queue-based model.
module tb_fetch_stage;
   logic        clk, rst;
   logic [31:0] pc, pc_next, imem_addr, redirect_pc, ifid_instr, ifid_pc;
   logic        pc_we, stall, redirect, ifid_valid;
   logic [15:0] imem_data;
   logic [15:0] mem [0:1023];
   int          total = 0, bad = 0;

   logic [15:0] pend[$];
   logic [31:0] ppc;
   logic        m_v;
   logic [31:0] m_i, m_p;

   typedef struct {
      logic        s, r;
      logic [31:0] rp;
      logic        v;
      logic [31:0] ins, ipc, npc;
   } vec_t;
   vec_t vec [13];

   assign imem_data = mem[imem_addr[9:0]];

   fetch_stage dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .pc_we(pc_we),
      .imem_addr(imem_addr), .imem_data(imem_data), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .ifid_valid(ifid_valid),
      .ifid_instr(ifid_instr), .ifid_pc(ifid_pc)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      pend.delete();
      m_v = 0; m_i = 0; m_p = 0;
   endtask

   // One cycle: drive at negedge, check next-PC, advance model, check IF/ID after the edge.
   task automatic step(input logic s, input logic r, input logic [31:0] rp);
      logic        we;
      logic [31:0] nx;
      logic [15:0] w;
      @(negedge clk);
      stall = s; redirect = r; redirect_pc = rp;
      #1;
      we = r | ~s;
      nx = r ? rp : pc + 32'd1;
      chk("pc_we", 64'(pc_we), 64'(we));
      chk("pc_next", 64'(pc_next), 64'(nx));
      chk("imem_addr", 64'(imem_addr), 64'(pc));
      w = mem[pc[9:0]];
      if (r) model_clear();
      else if (!s) begin
         if (pend.size() > 0) begin
            m_v = 1; m_i = {pend.pop_front(), w}; m_p = ppc;
         end else if (w[15]) begin
            pend.push_back(w); ppc = pc; m_v = 0; m_i = 0; m_p = 0;
         end else begin
            m_v = 1; m_i = {w, 16'h0000}; m_p = pc;
         end
      end
      @(posedge clk);
      #1;
      if (we) pc = nx;
      chk("valid", 64'(ifid_valid), 64'(m_v));
      chk("instr", 64'(ifid_instr), 64'(m_i));
      chk("ifid_pc", 64'(ifid_pc), 64'(m_p));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      #1;
      chk("rst_valid", 64'(ifid_valid), 64'd0);
      chk("rst_instr", 64'(ifid_instr), 64'd0);
      chk("rst_pc", 64'(ifid_pc), 64'd0);
      pc = 0;
      model_clear();
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      rst = 0; pc = 0; stall = 0; redirect = 0; redirect_pc = 0;
      model_clear();
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom) & 16'h7fff;
      mem[0] = 16'h1234; mem[1] = 16'h0042; mem[2] = 16'h0003; mem[3] = 16'h0004;
      mem[4] = 16'h8011; mem[5] = 16'hBEEF; mem[6] = 16'h0007; mem[7] = 16'h8123;
      mem[8] = 16'h5555; mem[10'h100] = 16'h0ABC; mem[10'h101] = 16'h8001;
      vec[0]  = '{0, 0, 0,     1, 32'h1234_0000, 0, 1};
      vec[1]  = '{0, 0, 0,     1, 32'h0042_0000, 1, 2};
      vec[2]  = '{0, 0, 0,     1, 32'h0003_0000, 2, 3};
      vec[3]  = '{0, 0, 0,     1, 32'h0004_0000, 3, 4};
      vec[4]  = '{0, 0, 0,     0, 0,             0, 5};
      vec[5]  = '{1, 0, 0,     0, 0,             0, 5};
      vec[6]  = '{1, 0, 0,     0, 0,             0, 5};
      vec[7]  = '{1, 0, 0,     0, 0,             0, 5};
      vec[8]  = '{0, 0, 0,     1, 32'h8011_BEEF, 4, 6};
      vec[9]  = '{0, 0, 0,     1, 32'h0007_0000, 6, 7};
      vec[10] = '{0, 0, 0,     0, 0,             0, 8};
      vec[11] = '{1, 1, 32'h100, 0, 0,           0, 32'h100};
      vec[12] = '{0, 0, 0,     1, 32'h0ABC_0000, 32'h100, 32'h101};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 64'(ifid_valid), 64'd0);
      chk("reset_instr", 64'(ifid_instr), 64'd0);
      chk("reset_pc", 64'(ifid_pc), 64'd0);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 13; i++) begin
         step(vec[i].s, vec[i].r, vec[i].rp);
         chk($sformatf("v%0d_valid", i), 64'(ifid_valid), 64'(vec[i].v));
         chk($sformatf("v%0d_instr", i), 64'(ifid_instr), 64'(vec[i].ins));
         chk($sformatf("v%0d_ifpc", i), 64'(ifid_pc), 64'(vec[i].ipc));
         chk($sformatf("v%0d_pc", i), 64'(pc), 64'(vec[i].npc));
      end
      // Async reset while in SECOND, then fetch must restart cleanly at 0 in FIRST.
      step(0, 0, 0);
      do_reset();
      step(0, 0, 0);
      chk("after_rst_instr", 64'(ifid_instr), 64'h1234_0000);
      chk("after_rst_valid", 64'(ifid_valid), 64'd1);
      // Async reset while outputs hold a valid instruction.
      do_reset();
      step(0, 0, 0);
      // PC wrap at the top of the address space.
      pc = 32'hFFFF_FFFF;
      mem[10'h3FF] = 16'h0123;
      step(0, 0, 0);
      chk("wrap_ifpc", 64'(ifid_pc), 64'hFFFF_FFFF);
      chk("wrap_instr", 64'(ifid_instr), 64'h0123_0000);
      chk("wrap_pc", 64'(pc), 64'd0);
      // Random run.
      for (int i = 0; i < 1024; i++)
         mem[i] = ($urandom_range(0, 9) < 4) ? (16'($urandom) | 16'h8000) : (16'($urandom) & 16'h7fff);
      do_reset();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 32'($urandom_range(0, 1023)));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline, sitting directly downstream of the `PC` register and upstream of decode. Each cycle it presents the PC to instruction memory and computes the next PC and the PC write enable. It assembles one- or two-word (16-bit word) instructions through a small state machine and loads the IF/ID pipeline register. Stall and branch-redirect/flush requests from the hazard and execute logic are applied here.

## Interface
- `ADDR_W`, 32, PC / memory address width.
- `WORD_W`, 16, instruction-memory word width; assembled instruction is `2*WORD_W`.
- `clk`  in  1  pipeline clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_W  current PC (output of `PC`).
- `pc_next`  out  ADDR_W  value driven to `PC` data input.
- `pc_we`  out  1  drives `PC` write_enable.
- `imem_addr`  out  ADDR_W  instruction-memory address (= `pc`).
- `imem_data`  in  WORD_W  instruction word, combinational read of `imem_addr`.
- `stall`  in  1  hold request from hazard unit.
- `redirect`  in  1  taken branch/jump/interrupt from a later stage.
- `redirect_pc`  in  ADDR_W  target PC when `redirect`=1.
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `ifid_instr`  out  2*WORD_W  assembled instruction, first word in upper half.
- `ifid_pc`  out  ADDR_W  address of the instruction's first word.

## Operation
- Memory is word-addressed: sequential `pc_next = pc + 1`, modulo 2^ADDR_W (0xFFFFFFFF wraps to 0).
- `imem_data[WORD_W-1]` = 1 marks a two-word instruction (second word is the immediate).
- FSM states: `FIRST` (reset state) and `SECOND`.
  - `FIRST`, flag 0: load IF/ID with `{imem_data, 16'h0000}`, valid 1, `ifid_pc=pc`. Stay `FIRST`.
  - `FIRST`, flag 1: capture word into `hold_word` and `pc` into `hold_pc`. Load IF/ID with a bubble (valid 0). Go to `SECOND`.
  - `SECOND`: load IF/ID with `{hold_word, imem_data}`, valid 1, `ifid_pc=hold_pc`. The flag bit of the second word is ignored. Go to `FIRST`.
- `pc_we = redirect | ~stall`.
- `pc_next = redirect ? redirect_pc : pc + 1`.
- Priority is `redirect` > `stall` > normal.
  - `redirect`: IF/ID loads a bubble (valid 0, instr 0, pc 0). FSM goes to `FIRST`. `hold_word` is discarded. This also applies in the same cycle as `stall`.
  - `stall` (no redirect): IF/ID, FSM, `hold_word` and `hold_pc` all hold their values, and `pc_we`=0.
- Reset (asynchronous, any state including `SECOND`):
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc`=0.
  - FSM goes to `FIRST`; `hold_word` and `hold_pc` are cleared to 0.
  - `pc_next`/`pc_we` are combinational and continue to follow `pc` during reset; `PC` itself resets to 0.

## Timing
- Memory read is combinational. IF/ID outputs are registered, so latency from `pc` to `ifid_*` is 1 cycle.
- A two-word instruction at address A appears on `ifid_*` one cycle after A+1 is fetched, i.e. 2 cycles after A. The cycle in between carries a bubble.
- `redirect` asserted in cycle N:
  - `pc` = target at N+1.
  - `ifid_valid`=0 at N+1.
  - First target instruction is valid at N+2.
- A stall of K cycles delays all outputs by exactly K cycles, with no instruction lost or duplicated.
- No combinational path exists from `ifid_*` back to any input.

## Structure
- Shared package `fetch_pkg`:
  - `WORD_W` and `ADDR_W` defaults.
  - `IMM_FLAG_BIT` = 15.
  - FSM state encoding (`FIRST`=0, `SECOND`=1).
  - `NOP_INSTR` = 32'h0000_0000.
- One sub-module, `ifid_reg`: parameterised register with load, flush and hold controls, and asynchronous active-low reset, holding valid/instr/pc. The FSM and next-PC logic stay in `fetch_stage`.

## Test plan
- Reset then release; memory 0:0x1234, 1:0x0042 → `ifid_instr`=0x1234_0000, pc 0, valid 1. Next cycle 0x0042_0000, pc 1. `pc` advances 0,1,2.
- Memory 4:0x8011, 5:0xBEEF → bubble after fetching 4, then `ifid_instr`=0x8011_BEEF, `ifid_pc`=4. `pc` advances to 6.
- `stall` held 3 cycles while in `SECOND` at pc 5 → `pc_we`=0, outputs frozen. After release, 0x8011_BEEF emitted exactly once.
- `redirect`=1, `redirect_pc`=0x100, asserted together with `stall` while in `SECOND` → next cycle `pc`=0x100, valid 0, FSM `FIRST`. Cycle after that, instruction from 0x100 is valid.
- `rst` asserted mid-`SECOND` (no clock edge) → `ifid_valid`/`ifid_instr`/`ifid_pc` go to 0 immediately. After release, fetch restarts at 0 in `FIRST`.
- `pc`=0xFFFF_FFFF, single-word instruction, no stall → `pc_next`=0, `ifid_pc`=0xFFFF_FFFF.
